// File: rtl/modinv_helper_sequencer_pkg.sv
// Shared definitions for the modular-inverter helper sequencer: micro-op kinds,
// sequencer states and micro-op field layout.
package modinv_helper_sequencer_pkg;

  // Kind occupies the top bits of a micro-op; the remaining low bits are the argument.
  localparam int unsigned KindBits = 2;

  typedef enum logic [1:0] {
    UopExec      = 2'd0,
    UopLoopBegin = 2'd1,
    UopLoopEnd   = 2'd2,
    UopHalt      = 2'd3
  } uop_kind_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StIssue  = 3'd3,
    StWait   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/modinv_helper_sequencer.sv
// Micro-program sequencer driving the inverter's helper engines from an external
// synchronous ROM, with one level of counted loops and sticky error reporting.
module modinv_helper_sequencer
  import modinv_helper_sequencer_pkg::*;
#(
  parameter int unsigned NUM_HELPERS     = 4,
  parameter int unsigned HELPER_IDX_BITS = 2,
  parameter int unsigned PROG_ADDR_BITS  = 6,
  parameter int unsigned UOP_WIDTH       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  output logic                      rdy,
  output logic                      done,
  output logic                      err,
  input  logic [PROG_ADDR_BITS-1:0] prog_start,
  output logic [PROG_ADDR_BITS-1:0] uop_addr,
  input  logic [UOP_WIDTH-1:0]      uop_din,
  output logic [NUM_HELPERS-1:0]    hlp_ena,
  input  logic [NUM_HELPERS-1:0]    hlp_rdy
);

  localparam int unsigned ArgBits = UOP_WIDTH - KindBits;

  seq_state_e                state_q, state_d;
  logic [PROG_ADDR_BITS-1:0] pc_q, pc_d;
  logic [PROG_ADDR_BITS-1:0] loop_pc_q, loop_pc_d;
  logic [ArgBits-1:0]        loop_cnt_q, loop_cnt_d;
  logic                      loop_act_q, loop_act_d;
  logic [HELPER_IDX_BITS-1:0] idx_q, idx_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  uop_kind_e          kind;
  logic [ArgBits-1:0] arg;
  logic               pc_last;

  assign kind    = uop_kind_e'(uop_din[UOP_WIDTH-1 -: KindBits]);
  assign arg     = uop_din[ArgBits-1:0];
  assign pc_last = &pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    loop_pc_d  = loop_pc_q;
    loop_cnt_d = loop_cnt_q;
    loop_act_d = loop_act_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (ena) begin
          pc_d       = prog_start;
          err_d      = 1'b0;
          loop_act_d = 1'b0;
          state_d    = StFetch;
        end
      end

      StFetch: state_d = StDecode;

      StDecode: begin
        unique case (kind)
          UopExec: begin
            if (32'(arg) >= NUM_HELPERS) begin
              err_d   = 1'b1;
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              idx_d   = arg[HELPER_IDX_BITS-1:0];
              state_d = StIssue;
            end
          end
          UopLoopBegin: begin
            if (loop_act_q || pc_last) begin
              err_d   = 1'b1;
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              loop_cnt_d = (arg == '0) ? ArgBits'(1) : arg;
              loop_pc_d  = pc_q + 1'b1;
              loop_act_d = 1'b1;
              pc_d       = pc_q + 1'b1;
              state_d    = StFetch;
            end
          end
          UopLoopEnd: begin
            if (!loop_act_q) begin
              err_d   = 1'b1;
              done_d  = 1'b1;
              state_d = StIdle;
            end else if (loop_cnt_q > ArgBits'(1)) begin
              loop_cnt_d = loop_cnt_q - 1'b1;
              pc_d       = loop_pc_q;
              state_d    = StFetch;
            end else begin
              loop_act_d = 1'b0;
              if (pc_last) begin
                err_d   = 1'b1;
                done_d  = 1'b1;
                state_d = StIdle;
              end else begin
                pc_d    = pc_q + 1'b1;
                state_d = StFetch;
              end
            end
          end
          UopHalt: begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        endcase
      end

      StIssue: state_d = StWait;

      // The helper drops rdy on the issue edge, so rdy here always means completion.
      StWait: begin
        if (hlp_rdy[idx_q]) begin
          if (pc_last) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = StFetch;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      loop_pc_q  <= '0;
      loop_cnt_q <= '0;
      loop_act_q <= 1'b0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      loop_pc_q  <= loop_pc_d;
      loop_cnt_q <= loop_cnt_d;
      loop_act_q <= loop_act_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Decoded from the state register so the strobe falls with an asynchronous reset.
  always_comb begin
    hlp_ena = '0;
    if (state_q == StIssue) hlp_ena[idx_q] = 1'b1;
  end

  assign rdy      = (state_q == StIdle);
  assign done     = done_q;
  assign err      = err_q;
  assign uop_addr = pc_q;

endmodule

// File: tb/tb_modinv_helper_sequencer.sv
// Self-checking bench: ROM and helper models around the sequencer, with a program
// interpreter predicting pulses, error and completion cycle.
module tb_modinv_helper_sequencer;

  localparam int NH = 4;
  localparam int AB = 6;
  localparam int UW = 8;
  localparam int CycLimit = 4000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          rdy, done, err;
  logic [AB-1:0] prog_start = '0;
  logic [AB-1:0] uop_addr;
  logic [UW-1:0] uop_din;
  logic [NH-1:0] hlp_ena, hlp_rdy;

  logic [UW-1:0] rom [64];
  int unsigned   lat [NH];
  int unsigned   busy [NH];

  int total = 0;
  int bad = 0;

  // Results of the last run
  int            got_cyc;
  logic          got_err, got_rdy, done_next;
  int            got_pulses [$];
  int            pulse_cyc [$];
  int            multi;
  logic [AB-1:0] addr_log [CycLimit+1];
  logic [NH-1:0] hlp_log [CycLimit+1];
  logic          err_log [CycLimit+1];

  // Reference model outputs
  int exp_cyc;
  bit exp_err;
  int exp_pulses [$];

  always #5 clk = ~clk;

  modinv_helper_sequencer #(
    .NUM_HELPERS    (NH),
    .HELPER_IDX_BITS(2),
    .PROG_ADDR_BITS (AB),
    .UOP_WIDTH      (UW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .rdy       (rdy),
    .done      (done),
    .err       (err),
    .prog_start(prog_start),
    .uop_addr  (uop_addr),
    .uop_din   (uop_din),
    .hlp_ena   (hlp_ena),
    .hlp_rdy   (hlp_rdy)
  );

  always @(posedge clk) uop_din <= rom[uop_addr];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NH; i++) begin
      if (!rst_n) busy[i] <= 0;
      else if (hlp_ena[i]) busy[i] <= lat[i];
      else if (busy[i] > 0) busy[i] <= busy[i] - 1;
    end
  end

  always_comb begin
    for (int i = 0; i < NH; i++) hlp_rdy[i] = (busy[i] == 0);
  end

  function automatic logic [UW-1:0] op(input int k, input int a);
    return UW'(((k & 3) << 6) | (a & 63));
  endfunction

  function automatic void clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = op(3, 0);
    for (int i = 0; i < NH; i++) lat[i] = 1;
  endfunction

  // Interprets the program from the micro-op rules, summing per-op cycle costs.
  function automatic void model(input int start);
    int pc, cnt, lpc, k, a;
    bit act;
    pc = start; cnt = 0; lpc = 0; act = 0;
    exp_pulses.delete();
    exp_cyc = 0;
    exp_err = 0;
    for (int step = 0; step < 100000; step++) begin
      k = int'(rom[pc][7:6]);
      a = int'(rom[pc][5:0]);
      if (k == 0) begin
        if (a >= NH) begin exp_cyc += 2; exp_err = 1; return; end
        exp_pulses.push_back(a);
        exp_cyc += 3 + int'(lat[a]) + 1;
        if (pc == 63) begin exp_err = 1; return; end
        pc++;
      end else if (k == 1) begin
        exp_cyc += 2;
        if (act || pc == 63) begin exp_err = 1; return; end
        cnt = (a == 0) ? 1 : a;
        lpc = pc + 1;
        act = 1;
        pc++;
      end else if (k == 2) begin
        exp_cyc += 2;
        if (!act) begin exp_err = 1; return; end
        if (cnt > 1) begin
          cnt--;
          pc = lpc;
        end else begin
          act = 0;
          if (pc == 63) begin exp_err = 1; return; end
          pc++;
        end
      end else begin
        exp_cyc += 2;
        return;
      end
    end
  endfunction

  function automatic bit pulses_equal();
    if (got_pulses.size() != exp_pulses.size()) return 0;
    foreach (got_pulses[i]) if (got_pulses[i] != exp_pulses[i]) return 0;
    return 1;
  endfunction

  // Starts a program and logs every cycle after the accepting edge until done.
  task automatic run_prog(input int start, input int poke_cyc);
    got_pulses.delete();
    pulse_cyc.delete();
    got_cyc = -1;
    multi = 0;
    got_err = 1'bx;
    got_rdy = 1'bx;
    @(negedge clk);
    prog_start = AB'(start);
    ena = 1'b1;
    @(posedge clk);
    #1 ena = 1'b0;
    for (int c = 1; c <= CycLimit; c++) begin
      @(negedge clk);
      addr_log[c] = uop_addr;
      hlp_log[c] = hlp_ena;
      err_log[c] = err;
      if (hlp_ena != '0) begin
        pulse_cyc.push_back(c);
        for (int i = 0; i < NH; i++) if (hlp_ena[i]) got_pulses.push_back(i);
        if ($countones(hlp_ena) != 1) multi++;
      end
      if (c == poke_cyc) begin
        ena = 1'b1;
        prog_start = AB'(start) ^ 6'h2a;
      end else if (c == poke_cyc + 1) begin
        ena = 1'b0;
      end
      if (done) begin
        got_cyc = c;
        got_err = err;
        got_rdy = rdy;
        break;
      end
    end
    ena = 1'b0;
    if (got_cyc < 0) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
    @(negedge clk);
    done_next = done;
  endtask

  task automatic test_reset();
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b want=1", rdy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (hlp_ena !== 4'b0) begin bad++; $display("FAIL reset_hlp_ena got=%b want=0000", hlp_ena); end
    total++; if (uop_addr !== 6'd0) begin bad++; $display("FAIL reset_uop_addr got=%0d want=0", uop_addr); end
  endtask

  task automatic test_single_exec();
    clear_rom();
    rom[0] = op(0, 0);
    rom[1] = op(3, 0);
    lat[0] = 9;
    run_prog(0, -1);
    total++; if (pulse_cyc.size() != 1 || pulse_cyc[0] != 3 || hlp_log[3] !== 4'b0001) begin
      bad++; $display("FAIL single_issue got_pulses=%0d hlp_ena_c3=%b want=1 pulse 0001 in cycle 3",
                      pulse_cyc.size(), hlp_log[3]);
    end
    total++; if (addr_log[13] !== 6'd0 || addr_log[14] !== 6'd1) begin
      bad++; $display("FAIL single_addr got c13=%0d c14=%0d want 0,1", addr_log[13], addr_log[14]);
    end
    total++; if (got_cyc != 16 || got_rdy !== 1'b1) begin
      bad++; $display("FAIL single_done got cyc=%0d rdy=%b want cyc=16 rdy=1", got_cyc, got_rdy);
    end
    total++; if (got_err !== 1'b0 || done_next !== 1'b0) begin
      bad++; $display("FAIL single_err_pulse got err=%b done_next=%b want 0,0", got_err, done_next);
    end
  endtask

  task automatic test_loop();
    clear_rom();
    rom[0] = op(1, 3);
    rom[1] = op(0, 2);
    rom[2] = op(2, 0);
    rom[3] = op(3, 0);
    lat[2] = 2;
    model(0);
    run_prog(0, -1);
    total++; if (got_pulses.size() != 3 || !pulses_equal()) begin
      bad++; $display("FAIL loop_pulses got=%0d want=3 pulses on helper 2", got_pulses.size());
    end
    total++; if (got_err !== 1'b0 || got_cyc != exp_cyc + 1 || done_next !== 1'b0) begin
      bad++; $display("FAIL loop_done got err=%b cyc=%0d want err=0 cyc=%0d", got_err, got_cyc,
                      exp_cyc + 1);
    end
  endtask

  task automatic test_bad_helper();
    clear_rom();
    rom[0] = op(0, 5);
    run_prog(0, -1);
    total++; if (got_err !== 1'b1 || got_cyc != 3 || got_pulses.size() != 0) begin
      bad++; $display("FAIL bad_helper got err=%b cyc=%0d pulses=%0d want err=1 cyc=3 pulses=0",
                      got_err, got_cyc, got_pulses.size());
    end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL bad_helper_sticky got=%b want=1", err); end
    rom[0] = op(3, 0);
    run_prog(0, -1);
    total++; if (err_log[1] !== 1'b0 || got_err !== 1'b0 || got_cyc != 3) begin
      bad++; $display("FAIL err_clear got err_c1=%b err=%b cyc=%0d want 0,0,3", err_log[1], got_err,
                      got_cyc);
    end
  endtask

  task automatic test_nested();
    clear_rom();
    rom[0] = op(1, 2);
    rom[1] = op(0, 0);
    rom[2] = op(1, 1);
    lat[0] = 2;
    run_prog(0, -1);
    total++; if (got_err !== 1'b1 || got_cyc != 11 || got_pulses.size() != 1) begin
      bad++; $display("FAIL nested got err=%b cyc=%0d pulses=%0d want err=1 cyc=11 pulses=1",
                      got_err, got_cyc, got_pulses.size());
    end
  endtask

  task automatic test_last_addr();
    clear_rom();
    rom[63] = op(0, 1);
    rom[0] = op(0, 0);
    lat[1] = 3;
    run_prog(63, -1);
    total++; if (got_err !== 1'b1 || got_cyc != 8 || got_pulses.size() != 1) begin
      bad++; $display("FAIL last_addr got err=%b cyc=%0d pulses=%0d want err=1 cyc=8 pulses=1",
                      got_err, got_cyc, got_pulses.size());
    end
    total++; if (got_cyc > 0 && addr_log[got_cyc] !== 6'd63) begin
      bad++; $display("FAIL last_addr_nowrap got=%0d want=63", addr_log[got_cyc]);
    end
  endtask

  task automatic test_reset_in_wait();
    clear_rom();
    rom[0] = op(0, 3);
    lat[3] = 20;
    @(negedge clk);
    prog_start = '0;
    ena = 1'b1;
    @(posedge clk);
    #1 ena = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL wait_busy got rdy=%b want=0", rdy); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (rdy !== 1'b1 || hlp_ena !== 4'b0 || uop_addr !== 6'd0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_in_wait got rdy=%b hlp_ena=%b addr=%0d done=%b want 1,0000,0,0",
                      rdy, hlp_ena, uop_addr, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rom[0] = op(0, 3);
    rom[1] = op(3, 0);
    lat[3] = 2;
    model(0);
    run_prog(0, -1);
    total++; if (got_err !== 1'b0 || got_cyc != exp_cyc + 1 || !pulses_equal()) begin
      bad++; $display("FAIL restart got err=%b cyc=%0d want err=0 cyc=%0d", got_err, got_cyc,
                      exp_cyc + 1);
    end
  endtask

  task automatic test_ena_in_wait();
    clear_rom();
    rom[0] = op(0, 1);
    rom[1] = op(0, 0);
    rom[2] = op(3, 0);
    lat[1] = 8;
    lat[0] = 1;
    model(0);
    run_prog(0, 6);
    total++; if (addr_log[7] !== 6'd0 || addr_log[8] !== 6'd0) begin
      bad++; $display("FAIL ena_in_wait_pc got c7=%0d c8=%0d want 0,0", addr_log[7], addr_log[8]);
    end
    total++; if (got_err !== 1'b0 || got_cyc != exp_cyc + 1 || !pulses_equal()) begin
      bad++; $display("FAIL ena_in_wait_run got err=%b cyc=%0d want err=0 cyc=%0d", got_err,
                      got_cyc, exp_cyc + 1);
    end
  endtask

  task automatic test_random();
    int r, start;
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 64; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 3) rom[i] = op(0, int'($urandom_range(4, 63)));
        else if (r < 55) rom[i] = op(0, int'($urandom_range(0, 3)));
        else if (r < 68) rom[i] = op(1, int'($urandom_range(0, 4)));
        else if (r < 82) rom[i] = op(2, int'($urandom_range(0, 63)));
        else rom[i] = op(3, 0);
      end
      for (int i = 0; i < NH; i++) lat[i] = $urandom_range(1, 6);
      start = int'($urandom_range(0, 63));
      model(start);
      run_prog(start, -1);
      total++; if (got_cyc != exp_cyc + 1 || got_err !== exp_err || !pulses_equal() || multi != 0
                   || done_next !== 1'b0) begin
        bad++; $display("FAIL random_%0d got cyc=%0d err=%b pulses=%0d multi=%0d want cyc=%0d err=%b pulses=%0d",
                        n, got_cyc, got_err, got_pulses.size(), multi, exp_cyc + 1, exp_err,
                        exp_pulses.size());
      end
    end
  endtask

  initial begin
    clear_rom();
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_exec();
    test_loop();
    test_bad_helper();
    test_nested();
    test_last_addr();
    test_reset_in_wait();
    test_ena_in_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
